// File: rtl/snake_engine.sv
// Snake game engine: owns the body queue and sequences grid-RAM clears, head reads and head/tail writes.
// Every RAM-port and status output is a flop loaded with the value for the state being entered.
module snake_engine #(
  parameter int unsigned GRID_W  = 14,
  parameter int unsigned GRID_H  = 14,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic [1:0] i_dir,
  input  logic       i_restart,
  output logic [7:0] o_addr,
  output logic [1:0] o_wdata,
  output logic       o_write,
  input  logic [1:0] i_rdata,
  output logic       o_busy,
  output logic       o_ate,
  output logic       o_game_over,
  output logic [5:0] o_len
);

  localparam int unsigned CELLS     = GRID_W * GRID_H;
  localparam int unsigned PW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned INIT_LEN  = 3;
  localparam logic [7:0]  INIT_TAIL = 8'd100;
  localparam logic [7:0]  HEAD_ROW0 = 8'((32'(INIT_TAIL) + INIT_LEN - 1) / GRID_W);
  localparam logic [7:0]  HEAD_COL0 = 8'((32'(INIT_TAIL) + INIT_LEN - 1) % GRID_W);

  typedef enum logic [3:0] {
    S_CLEAR, S_INIT, S_READY, S_CALC, S_READ, S_CHECK, S_WR_HEAD, S_CLR_TAIL, S_DEAD
  } state_t;

  state_t          state, state_d;
  logic [7:0]      cnt, cnt_d;
  logic [1:0]      dir_req, dir_req_d, cur_dir, cur_dir_d, eff_dir;
  logic [7:0]      head_row, head_row_d, head_col, head_col_d;
  logic [7:0]      nh_addr, nh_addr_d, nh_row, nh_row_d, nh_col, nh_col_d;
  logic            grow, grow_d, off_grid;
  logic [PW-1:0]   head_ptr, head_ptr_d, tail_ptr, tail_ptr_d;
  logic [5:0]      len_d;
  logic [7:0]      addr_d;
  logic [1:0]      wdata_d;
  logic            write_d, ate_d;

  logic [7:0]      queue [MAX_LEN];
  logic            q_we;
  logic [PW-1:0]   q_idx;
  logic [7:0]      q_data;
  logic [7:0]      q_head, q_tail;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (32'(p) == MAX_LEN - 1) ? '0 : PW'(p + 1'b1);
  endfunction

  assign q_head  = queue[head_ptr];
  assign q_tail  = queue[tail_ptr];
  // A request exactly opposite the current heading is ignored.
  assign eff_dir = ((dir_req ^ cur_dir) == 2'd2) ? cur_dir : dir_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_CLEAR;
      cnt         <= '0;
      dir_req     <= 2'd1;
      cur_dir     <= 2'd1;
      head_row    <= '0;
      head_col    <= '0;
      nh_addr     <= '0;
      nh_row      <= '0;
      nh_col      <= '0;
      grow        <= 1'b0;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      o_len       <= '0;
      o_addr      <= '0;
      o_wdata     <= 2'b00;
      o_write     <= 1'b0;
      o_ate       <= 1'b0;
      o_busy      <= 1'b1;
      o_game_over <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      dir_req     <= dir_req_d;
      cur_dir     <= cur_dir_d;
      head_row    <= head_row_d;
      head_col    <= head_col_d;
      nh_addr     <= nh_addr_d;
      nh_row      <= nh_row_d;
      nh_col      <= nh_col_d;
      grow        <= grow_d;
      head_ptr    <= head_ptr_d;
      tail_ptr    <= tail_ptr_d;
      o_len       <= len_d;
      o_addr      <= addr_d;
      o_wdata     <= wdata_d;
      o_write     <= write_d;
      o_ate       <= ate_d;
      o_busy      <= !(state_d == S_READY || state_d == S_DEAD);
      o_game_over <= (state_d == S_DEAD);
    end
  end

  always_ff @(posedge i_clk) begin
    if (q_we) queue[q_idx] <= q_data;
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    dir_req_d  = dir_req;
    cur_dir_d  = cur_dir;
    head_row_d = head_row;
    head_col_d = head_col;
    nh_addr_d  = nh_addr;
    nh_row_d   = nh_row;
    nh_col_d   = nh_col;
    grow_d     = grow;
    head_ptr_d = head_ptr;
    tail_ptr_d = tail_ptr;
    len_d      = o_len;
    addr_d     = o_addr;
    wdata_d    = 2'b00;
    write_d    = 1'b0;
    ate_d      = 1'b0;
    q_we       = 1'b0;
    q_idx      = head_ptr;
    q_data     = nh_addr;
    off_grid   = 1'b0;
    case (state)
      S_CLEAR: begin
        if (cnt < 8'(CELLS)) begin
          write_d = 1'b1;
          addr_d  = cnt;
          cnt_d   = cnt + 8'd1;
        end else begin
          // First body write issues on the way into INIT so the three writes stay back to back.
          state_d = S_INIT;
          write_d = 1'b1;
          wdata_d = 2'b01;
          addr_d  = INIT_TAIL;
          q_we    = 1'b1;
          q_idx   = '0;
          q_data  = INIT_TAIL;
          cnt_d   = 8'd1;
        end
      end
      S_INIT: begin
        if (32'(cnt) < INIT_LEN) begin
          write_d = 1'b1;
          wdata_d = 2'b01;
          addr_d  = INIT_TAIL + cnt;
          q_we    = 1'b1;
          q_idx   = PW'(cnt);
          q_data  = INIT_TAIL + cnt;
          cnt_d   = cnt + 8'd1;
        end else begin
          state_d    = S_READY;
          tail_ptr_d = '0;
          head_ptr_d = PW'(INIT_LEN - 1);
          len_d      = 6'(INIT_LEN);
          cur_dir_d  = 2'd1;
          head_row_d = HEAD_ROW0;
          head_col_d = HEAD_COL0;
        end
      end
      S_READY: begin
        if (i_tick) begin
          dir_req_d = i_dir;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        cur_dir_d = eff_dir;
        nh_row_d  = head_row;
        nh_col_d  = head_col;
        case (eff_dir)
          2'd0: begin
            off_grid  = (head_row == 8'd0);
            nh_row_d  = head_row - 8'd1;
            nh_addr_d = q_head - 8'(GRID_W);
          end
          2'd1: begin
            off_grid  = (head_col == 8'(GRID_W - 1));
            nh_col_d  = head_col + 8'd1;
            nh_addr_d = q_head + 8'd1;
          end
          2'd2: begin
            off_grid  = (head_row == 8'(GRID_H - 1));
            nh_row_d  = head_row + 8'd1;
            nh_addr_d = q_head + 8'(GRID_W);
          end
          default: begin
            off_grid  = (head_col == 8'd0);
            nh_col_d  = head_col - 8'd1;
            nh_addr_d = q_head - 8'd1;
          end
        endcase
        if (off_grid) begin
          state_d = S_DEAD;
        end else begin
          state_d = S_READ;
          addr_d  = nh_addr_d;
        end
      end
      S_READ: state_d = S_CHECK;
      S_CHECK: begin
        // Body (incl. current tail) and reserved cells are both fatal.
        if (i_rdata[0]) begin
          state_d = S_DEAD;
        end else begin
          grow_d  = (i_rdata == 2'b10);
          ate_d   = (i_rdata == 2'b10);
          state_d = S_WR_HEAD;
          write_d = 1'b1;
          wdata_d = 2'b01;
          addr_d  = nh_addr;
        end
      end
      S_WR_HEAD: begin
        q_we       = 1'b1;
        q_idx      = inc_ptr(head_ptr);
        q_data     = nh_addr;
        head_ptr_d = inc_ptr(head_ptr);
        head_row_d = nh_row;
        head_col_d = nh_col;
        if (grow && (32'(o_len) < MAX_LEN)) begin
          len_d   = o_len + 6'd1;
          state_d = S_READY;
        end else begin
          // Tail address is read before the push lands, so a full queue is safe.
          state_d = S_CLR_TAIL;
          write_d = 1'b1;
          addr_d  = q_tail;
        end
      end
      S_CLR_TAIL: begin
        tail_ptr_d = inc_ptr(tail_ptr);
        state_d    = S_READY;
      end
      S_DEAD: begin
        if (i_restart) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          len_d   = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: init sequence, moves, growth, saturation, death, restart and reset.
module tb_snake_engine;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_tick = 1'b0;
  logic [1:0] i_dir = 2'd0;
  logic       i_restart = 1'b0;
  logic [7:0] o_addr;
  logic [1:0] o_wdata;
  logic       o_write;
  logic [1:0] i_rdata = 2'b00;
  logic       o_busy;
  logic       o_ate;
  logic       o_game_over;
  logic [5:0] o_len;

  int tests = 0;
  int fails = 0;

  logic       s_wr   [1:6];
  logic [1:0] s_wd   [1:6];
  logic [7:0] s_ad   [1:6];
  logic       s_ate  [1:6];
  logic       s_busy [1:6];
  logic       s_go   [1:6];
  logic [5:0] s_len  [1:6];

  int body [$];
  int hrow, hcol, len_m, nr, nc, nh;
  logic [1:0] mdir, pend, d;

  snake_engine dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_dir(i_dir), .i_restart(i_restart),
    .o_addr(o_addr), .o_wdata(o_wdata), .o_write(o_write), .i_rdata(i_rdata),
    .o_busy(o_busy), .o_ate(o_ate), .o_game_over(o_game_over), .o_len(o_len)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // 196 clears then the three initial body cells, then idle in READY.
  task automatic run_init(input string tag);
    logic [10:0] exp_v;
    for (int k = 0; k < 199; k++) begin
      step();
      exp_v = (k < 196) ? {1'b1, 2'b00, 8'(k)} : {1'b1, 2'b01, 8'(100 + k - 196)};
      chk({tag, " seq"}, {o_write, o_wdata, o_addr}, exp_v);
    end
    chk({tag, " busy_last"}, o_busy, 1'b1);
    step();
    chk({tag, " ready"}, {o_busy, o_write, o_game_over, o_len}, {3'b000, 6'd3});
  endtask

  task automatic do_move(input logic [1:0] dir, input logic [1:0] rd, input bit noise);
    i_rdata = rd;
    i_dir   = dir;
    i_tick  = 1'b1;
    step();
    i_tick  = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (noise) begin
        i_tick    = (k <= 3);
        i_restart = (k <= 3);
        i_dir     = dir ^ 2'd1;
      end
      step();
      s_wr[k] = o_write; s_wd[k] = o_wdata; s_ad[k] = o_addr; s_ate[k] = o_ate;
      s_busy[k] = o_busy; s_go[k] = o_game_over; s_len[k] = o_len;
    end
    i_tick = 1'b0;
    i_restart = 1'b0;
  endtask

  task automatic check_move(input string tag, input int head, input bit ate, input bit short_mv,
                            input int tail, input int len);
    chk({tag, " read"}, {s_wr[1], s_ad[1], s_busy[1]}, {1'b0, 8'(head), 1'b1});
    chk({tag, " check"}, {s_wr[2], s_ate[2]}, 2'b00);
    chk({tag, " wr_head"}, {s_wr[3], s_wd[3], s_ad[3], s_ate[3]}, {1'b1, 2'b01, 8'(head), ate});
    if (short_mv) begin
      chk({tag, " grow_done"}, {s_busy[4], s_wr[4], s_ate[4]}, 3'b000);
    end else begin
      chk({tag, " clr_tail"}, {s_busy[4], s_wr[4], s_wd[4], s_ad[4], s_ate[4]},
          {1'b1, 1'b1, 2'b00, 8'(tail), 1'b0});
      chk({tag, " done"}, {s_busy[5], s_wr[5]}, 2'b00);
    end
    chk({tag, " len"}, {s_go[6], s_busy[6], s_len[6]}, {2'b00, 6'(len)});
  endtask

  initial begin
    repeat (3) step();
    chk("rst write", o_write, 1'b0);
    chk("rst addr", o_addr, 8'd0);
    chk("rst wdata", o_wdata, 2'b00);
    chk("rst ate", o_ate, 1'b0);
    chk("rst game_over", o_game_over, 1'b0);
    chk("rst len", o_len, 6'd0);
    chk("rst busy", o_busy, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_init("init");

    do_move(2'd1, 2'b00, 1'b0);
    check_move("mv_right", 103, 1'b0, 1'b0, 100, 3);

    // Grow, with tick/restart noise while busy.
    do_move(2'd1, 2'b10, 1'b1);
    check_move("mv_grow", 104, 1'b1, 1'b1, 0, 4);
    chk("grow ate_once", {s_ate[1], s_ate[2], s_ate[4], s_ate[5]}, 4'b0000);

    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    step();
    chk("restart_in_ready", {o_busy, o_write, o_game_over, o_len}, {3'b000, 6'd4});

    do_move(2'd1, 2'b00, 1'b0);
    check_move("mv_after", 105, 1'b0, 1'b0, 101, 4);
    for (int i = 0; i < 6; i++) begin
      do_move(2'd1, 2'b00, 1'b0);
      chk("walk head", {s_wr[3], s_ad[3], s_ad[4]}, {1'b1, 8'(106 + i), 8'(102 + i)});
    end

    // Head at column 13: stepping right leaves the grid.
    do_move(2'd1, 2'b00, 1'b0);
    chk("wall dead", {s_go[1], s_wr[1], s_busy[1]}, 3'b100);
    chk("wall no_write", {s_wr[2], s_wr[3], s_wr[4], s_wr[5], s_go[6]}, 5'b00001);
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    step();
    chk("dead tick", {o_game_over, o_busy, o_write}, 3'b100);
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    chk("restart clear", {o_game_over, o_busy, o_write}, 3'b010);
    run_init("reinit");

    do_move(2'd3, 2'b00, 1'b0);
    check_move("mv_reverse", 103, 1'b0, 1'b0, 100, 3);

    // Reset asserted while the tail clear is on the port.
    i_dir = 2'd1;
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    repeat (4) step();
    chk("pre_rst clr_tail", {o_write, o_wdata, o_addr}, {1'b1, 2'b00, 8'd101});
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst outputs", {o_write, o_addr, o_wdata, o_ate, o_game_over, o_busy, o_len},
        {1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b1, 6'd0});
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_init("rst_init");

    // Zig-zag over food until the length saturates at 32.
    body = {100, 101, 102};
    hrow = 7; hcol = 4; len_m = 3; mdir = 2'd1; pend = 2'd3;
    for (int i = 0; i < 30; i++) begin
      if ((mdir == 2'd1 && hcol == 13) || (mdir == 2'd3 && hcol == 0)) begin
        pend = (mdir == 2'd1) ? 2'd3 : 2'd1;
        d = 2'd2;
      end else if (mdir == 2'd2) begin
        d = pend;
      end else begin
        d = mdir;
      end
      nr = hrow + ((d == 2'd2) ? 1 : (d == 2'd0) ? -1 : 0);
      nc = hcol + ((d == 2'd1) ? 1 : (d == 2'd3) ? -1 : 0);
      nh = nr * 14 + nc;
      do_move(d, 2'b10, 1'b0);
      check_move("mv_food", nh, 1'b1, len_m < 32, body[0], (len_m < 32) ? len_m + 1 : len_m);
      body.push_back(nh);
      if (len_m < 32) len_m++;
      else void'(body.pop_front());
      hrow = nr; hcol = nc; mdir = d;
    end

    // Body cell ahead is a collision.
    nh = hrow * 14 + hcol + 1;
    do_move(2'd1, 2'b01, 1'b0);
    chk("collide read", {s_wr[1], s_ad[1]}, {1'b0, 8'(nh)});
    chk("collide dead", {s_go[2], s_go[3], s_wr[3], s_busy[3], s_ate[3]}, 5'b01000);
    chk("collide len", o_len, 6'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
